// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode: up to 2 enq / 2 deq per cycle; FETCH_QUEUE_BYPASS_EN lets an empty queue forward incoming slots.
// Latency: enqueued entries appear on D1/D2 the cycle after the edge that writes them (zero cycles from the inputs with bypass enabled).
// Backpressure: registered stall rises when occupancy exceeds DEPTH-4, leaving room for the bundle in flight; nothing is ever dropped.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [15:0]      I1,
  input  logic [15:0]      I2,
  input  logic             I1V,
  input  logic             I2V,
  input  logic             I1P,
  input  logic             I2P,
  input  logic [15:0]      I1PC,
  input  logic [15:0]      I2PC,
  output logic             stall,
  input  logic [1:0]       deq_cnt,
  output logic [15:0]      D1,
  output logic [15:0]      D2,
  output logic             D1V,
  output logic             D2V,
  output logic             D1P,
  output logic             D2P,
  output logic [15:0]      D1PC,
  output logic [15:0]      D2PC,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        pred;
  } entry_t;

  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 4);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             new_bundle;

  entry_t      slot1, slot2, in0, in1, hd0, hd1, wq0, wq1;
  logic        wr_en1, wr_en2, in0_vld, in1_vld, hd0_vld, hd1_vld, wq0_vld, wq1_vld;
  logic        bypass;
  logic [1:0]  enq_n, deq_req, head_n, eff_deq, byp_n, wr_n, rd_adv;
  logic [CW-1:0] count_next;

  assign slot1 = '{instr: I1, pc: I1PC, pred: I1P};
  assign slot2 = '{instr: I2, pc: I2PC, pred: I2P};

  // A held bundle (new_bundle = 0) was already taken; I2 is dropped behind a predicted-taken I1.
  assign wr_en1 = new_bundle && I1V;
  assign wr_en2 = new_bundle && I2V && !(I1V && I1P);
  assign enq_n  = {1'b0, wr_en1} + {1'b0, wr_en2};

  // Compact the valid slots so the oldest incoming instruction is always in0.
  assign in0_vld = wr_en1 || wr_en2;
  assign in1_vld = wr_en1 && wr_en2;
  assign in0     = wr_en1 ? slot1 : slot2;
  assign in1     = slot2;

  assign deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count == '0) && new_bundle;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    hd0     = mem[rd_ptr];
    hd1     = mem[rd_ptr + PTR_W'(1)];
    hd0_vld = (count >= CW'(1));
    hd1_vld = (count >= CW'(2));
    if (bypass) begin
      hd0     = in0;
      hd1     = in1;
      hd0_vld = in0_vld;
      hd1_vld = in1_vld;
    end
    head_n  = {1'b0, hd0_vld} + {1'b0, hd1_vld};
    eff_deq = (deq_req > head_n) ? head_n : deq_req;
    byp_n   = bypass ? eff_deq : 2'd0;

    // Slots consumed straight off the inputs are never written.
    wq0     = in0;
    wq0_vld = in0_vld;
    wq1     = in1;
    wq1_vld = in1_vld;
    if (byp_n == 2'd1) begin
      wq0     = in1;
      wq0_vld = in1_vld;
      wq1_vld = 1'b0;
    end else if (byp_n == 2'd2) begin
      wq0_vld = 1'b0;
      wq1_vld = 1'b0;
    end
    wr_n   = enq_n - byp_n;
    rd_adv = eff_deq - byp_n;
  end

  assign count_next = count + CW'(enq_n) - CW'(eff_deq);

  assign D1V  = hd0_vld;
  assign D2V  = hd1_vld;
  assign D1   = hd0_vld ? hd0.instr : 16'h0;
  assign D2   = hd1_vld ? hd1.instr : 16'h0;
  assign D1PC = hd0_vld ? hd0.pc : 16'h0;
  assign D2PC = hd1_vld ? hd1.pc : 16'h0;
  assign D1P  = hd0_vld && hd0.pred;
  assign D2P  = hd1_vld && hd1.pred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      stall      <= 1'b0;
      new_bundle <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      stall      <= 1'b0;
      new_bundle <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr + PTR_W'(rd_adv);
      wr_ptr     <= wr_ptr + PTR_W'(wr_n);
      count      <= count_next;
      stall      <= (count_next > STALL_TH);
      new_bundle <= !stall;
    end
  end

  // Storage is not reset; D* are masked by the valid bits until entries are written.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (wq0_vld) mem[wr_ptr] <= wq0;
      if (wq1_vld) mem[wr_ptr + PTR_W'(1)] <= wq1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a small fetch model launches bundles only after edges that saw stall low.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst, flush;
  logic [15:0] I1, I2, I1PC, I2PC;
  logic I1V, I2V, I1P, I2P;
  logic stall;
  logic [1:0] deq_cnt;
  logic [15:0] D1, D2, D1PC, D2PC;
  logic D1V, D2V, D1P, D2P;
  logic [PTR_W:0] count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .I1(I1), .I2(I2), .I1V(I1V), .I2V(I2V), .I1P(I1P), .I2P(I2P),
    .I1PC(I1PC), .I2PC(I2PC), .stall(stall), .deq_cnt(deq_cnt),
    .D1(D1), .D2(D2), .D1V(D1V), .D2V(D2V), .D1P(D1P), .D2P(D2P),
    .D1PC(D1PC), .D2PC(D2PC), .count(count)
  );

  typedef struct packed {
    logic        v1;
    logic        p1;
    logic [15:0] i1;
    logic [15:0] pc1;
    logic        v2;
    logic        p2;
    logic [15:0] i2;
    logic [15:0] pc2;
  } bundle_t;

  bundle_t fq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bundle_t b);
    I1V = b.v1; I1P = b.p1; I1 = b.i1; I1PC = b.pc1;
    I2V = b.v2; I2P = b.p2; I2 = b.i2; I2PC = b.pc2;
  endtask

  // Two valid, unpredicted instructions numbered n and n+1.
  function automatic bundle_t pair(input int n);
    bundle_t b;
    b.v1 = 1'b1; b.p1 = 1'b0; b.i1 = 16'hA000 + 16'(n);     b.pc1 = 16'h0200 + 16'(2*n);
    b.v2 = 1'b1; b.p2 = 1'b0; b.i2 = 16'hA000 + 16'(n + 1); b.pc2 = 16'h0200 + 16'(2*n + 2);
    return b;
  endfunction

  // One clock; fetch launches its next bundle only if it saw stall low at this edge.
  task automatic cyc(input logic [1:0] d);
    logic stall_s;
    deq_cnt = d;
    stall_s = stall;
    @(posedge clk);
    #1;
    deq_cnt = 2'd0;
    flush   = 1'b0;
    if (!stall_s) begin
      if (fq.size() != 0) drive(fq.pop_front());
      else drive('0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bundle_t b;
    rst = 1'b1; flush = 1'b0; deq_cnt = 2'd0;
    drive('0);
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_d1v", 32'(D1V), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_d1", 32'(D1), 0);
    rst = 1'b0;

    // Basic two-wide enqueue
    b = '{v1: 1'b1, p1: 1'b0, i1: 16'h1234, pc1: 16'h0000,
          v2: 1'b1, p2: 1'b0, i2: 16'h5678, pc2: 16'h0002};
    fq.push_back(b);
    cyc(0);
    cyc(0);
    chk("basic_count", 32'(count), 2);
    chk("basic_d1", 32'(D1), 32'h1234);
    chk("basic_d1pc", 32'(D1PC), 32'h0000);
    chk("basic_d2", 32'(D2), 32'h5678);
    chk("basic_d2pc", 32'(D2PC), 32'h0002);
    chk("basic_d2v", 32'(D2V), 1);

    // Taken-branch drop after draining the queue
    b = '{v1: 1'b1, p1: 1'b1, i1: 16'hBEEF, pc1: 16'h0010,
          v2: 1'b1, p2: 1'b0, i2: 16'hDEAD, pc2: 16'h0012};
    fq.push_back(b);
    cyc(2);
    cyc(0);
    chk("taken_count", 32'(count), 1);
    chk("taken_d1", 32'(D1), 32'hBEEF);
    chk("taken_d1p", 32'(D1P), 1);
    chk("taken_d2v", 32'(D2V), 0);
    chk("taken_d2", 32'(D2), 0);

    // Dequeue request larger than occupancy
    cyc(2);
    chk("underflow_count", 32'(count), 0);
    chk("underflow_d1v", 32'(D1V), 0);

    // Back-pressure: four bundles from empty, rd_ptr = wr_ptr = 3
    for (int k = 0; k < 4; k++) fq.push_back(pair(2*k));
    cyc(0);
    cyc(0);
    chk("bp_count2", 32'(count), 2);
    chk("bp_stall2", 32'(stall), 0);
    cyc(0);
    chk("bp_count4", 32'(count), 4);
    chk("bp_stall4", 32'(stall), 0);
    cyc(0);
    chk("bp_count6", 32'(count), 6);
    chk("bp_stall6", 32'(stall), 1);
    cyc(0);
    chk("bp_count8", 32'(count), 8);
    chk("bp_stall8", 32'(stall), 1);
    cyc(0);
    chk("bp_hold_count", 32'(count), 8);
    chk("bp_d1", 32'(D1), 32'hA000);
    chk("bp_d2", 32'(D2), 32'hA001);
    cyc(2);
    chk("drain_count6", 32'(count), 6);
    chk("drain_stall6", 32'(stall), 1);
    chk("drain_d1", 32'(D1), 32'hA002);
    cyc(3);
    chk("drain_count4", 32'(count), 4);
    chk("drain_stall4", 32'(stall), 0);
    cyc(0);
    chk("drain_noreenq", 32'(count), 4);

    // Wrap: rd_ptr = 7, second head is entry 0
    chk("wrap_d1", 32'(D1), 32'hA004);
    chk("wrap_d1pc", 32'(D1PC), 32'h0208);
    chk("wrap_d2", 32'(D2), 32'hA005);
    chk("wrap_d2pc", 32'(D2PC), 32'h020A);

    // Flush with a full queue and a held bundle
    fq.push_back(pair(8));
    fq.push_back(pair(10));
    cyc(0);
    cyc(0);
    chk("pre_flush_count6", 32'(count), 6);
    cyc(0);
    chk("pre_flush_count8", 32'(count), 8);
    flush = 1'b1;
    cyc(0);
    chk("flush_count", 32'(count), 0);
    chk("flush_d1v", 32'(D1V), 0);
    chk("flush_stall", 32'(stall), 0);
    cyc(0);
    chk("flush_held_dropped", 32'(count), 0);

    // Asynchronous reset mid-run at count = 5 with a bundle held on the inputs
    fq.push_back(pair(20));
    fq.push_back(pair(22));
    b = pair(24);
    b.v2 = 1'b0;
    fq.push_back(b);
    fq.push_back(pair(26));
    cyc(0);
    cyc(0);
    cyc(0);
    cyc(0);
    chk("pre_rst_count5", 32'(count), 5);
    chk("pre_rst_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_d1v", 32'(D1V), 0);
    chk("arst_d2v", 32'(D2V), 0);
    chk("arst_stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0);
    chk("arst_held_dropped", 32'(count), 0);
    cyc(0);
    chk("arst_idle", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Receiving end of the fetch-bundle interface. Accepts up to two instructions per cycle from the fetch stage (instruction, PC and prediction bit per slot) and buffers them in a circular instruction queue.
- Presents up to two oldest entries per cycle to decode and drives the registered `stall` back to fetch.
- Sits between fetch and decode; `flush` empties it on redirect.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 8.
- PTR_W, $clog2(DEPTH), pointer width; occupancy counter is PTR_W+1 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous queue clear (redirect/mispredict).
- I1, I2  in  16 each  fetched instructions.
- I1V, I2V  in  1 each  slot valid.
- I1P, I2P  in  1 each  predicted-taken bits.
- I1PC, I2PC  in  16 each  slot PCs.
- stall  out  1  registered; fetch holds when high.
- deq_cnt  in  2  entries decode consumes this cycle (0..2; 3 treated as 2).
- D1, D2  out  16 each  oldest / second-oldest instruction.
- D1V, D2V  out  1 each  head entries valid.
- D1P, D2P  out  1 each  prediction bits of head entries.
- D1PC, D2PC  out  16 each  PCs of head entries.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (rst high, async):
  - rd_ptr = wr_ptr = count = 0; stall = 0; internal new_bundle flag = 0.
  - All D* outputs read 0.
  - Entry storage need not be cleared.
- Entry format: {instr[15:0], pc[15:0], pred}.
- Bundle freshness: fetch updates its outputs only at edges where it sampled stall = 0.
  - new_bundle register <= !stall each edge (0 after reset or flush).
  - Bundle inputs are enqueued only in cycles where new_bundle = 1; a held bundle is never enqueued twice.
- Enqueue rules, in a cycle with new_bundle = 1:
  - Slot 1 is written if I1V.
  - Slot 2 is written if I2V && !(I1V && I1P); I2 is dropped behind a predicted-taken I1.
  - Valid slots are written in order I1 then I2 to consecutive positions at wr_ptr. wr_ptr advances by 0/1/2 modulo DEPTH.
  - I2V without I1V enqueues I2 alone.
- Dequeue:
  - eff_deq = min(deq_cnt clamped to 2, count at start of cycle). rd_ptr advances by eff_deq modulo DEPTH.
  - Entries enqueued this cycle are not dequeuable this cycle (unless the bypass feature is enabled).
- Occupancy: count_next = count + enq_n − eff_deq; enqueue and dequeue in the same cycle are both applied.
- Read outputs are combinational from storage:
  - D1 = entry[rd_ptr], D1V = (count >= 1).
  - D2 = entry[rd_ptr+1 mod DEPTH], D2V = (count >= 2).
  - Data/PC/pred outputs read 0 when the matching valid is 0.
- Stall: stall <= (count_next > DEPTH−4).
  - The 4-entry margin covers the bundle being enqueued plus the bundle fetch launches on the same edge.
  - Overflow is impossible; no bundle is ever lost.
- Flush (highest priority below rst): at the edge, rd_ptr = wr_ptr = count = 0, stall = 0, new_bundle = 0. Same-cycle enqueue and dequeue are discarded.
- Pointer wrap-around is transparent; D2 reads across the DEPTH−1 → 0 boundary.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count = 0 and new_bundle = 1, D1/D2 (and D*V/D*P/D*PC) combinationally show the incoming slots.
  - eff_deq may consume them in the same cycle; consumed slots are not written.
  - Unconsumed slots are written at wr_ptr as normal.
- Undefined: no bypass; minimum fetch-to-decode latency is one cycle.

Test Plan:
1. Reset: assert rst mid-run with count = 5 -> immediately count = 0, D1V = D2V = 0, stall = 0; after release, the held fetch bundle is not enqueued.
2. Basic enqueue/read: one bundle I1 = 0x1234 @ 0x0000 and I2 = 0x5678 @ 0x0002 (both valid), deq_cnt = 0 -> next cycle D1 = 0x1234, D1PC = 0x0000, D2 = 0x5678, D2PC = 0x0002, count = 2.
3. Taken-branch drop: bundle with I1V = I2V = 1 and I1P = 1 -> count += 1, D1P = 1, D2V = 0.
4. Back-pressure, DEPTH = 8, deq_cnt = 0, four consecutive 2-instruction bundles from empty:
   - Count reaches 2, 4, 6 -> stall rises after the third.
   - Fourth in-flight bundle still enqueued -> count = 8, no loss.
   - Then deq_cnt = 2 twice -> count 6 (stall stays 1), then 4 (stall drops).
5. Wrap-around: fill and drain so rd_ptr = 7 with count = 2 -> D1 = entry 7, D2 = entry 0, correct values.
6. Flush with count = 8 and fetch bundle held -> next cycle count = 0, D1V = 0, stall = 0. Also deq_cnt = 2 with count = 1 -> count = 0, no underflow.
